// File: rtl/lcd_pkg.sv
// lcd_pkg: LCD bus pin map, command opcodes, DDRAM line map and decoder state encoding
package lcd_pkg;
  localparam int LCD_E = 5;
  localparam int LCD_RS = 4;
  localparam int LCD_D_HI = 3;
  localparam int LCD_D_LO = 0;
  localparam logic [7:0] CMD_DDRAM_MASK = 8'h80;
  localparam logic [7:0] CMD_DDRAM = 8'h80;
  localparam logic [7:0] CMD_FUNC_MASK = 8'hE0;
  localparam logic [7:0] CMD_FUNC = 8'h20;
  localparam logic [7:0] CMD_SHIFT_MASK = 8'hF0;
  localparam logic [7:0] CMD_SHIFT = 8'h10;
  localparam logic [7:0] CMD_ENTRY_MASK = 8'hFC;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_HOME_MASK = 8'hFE;
  localparam logic [7:0] CMD_HOME = 8'h02;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [3:0] NIB_INIT_4BIT = 4'h2;
  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam logic [6:0] LINE0_END = 7'h27;
  localparam logic [6:0] LINE1_END = 7'h67;
  localparam logic [1:0] ST_INIT8 = 2'd0;
  localparam logic [1:0] ST_HI = 2'd1;
  localparam logic [1:0] ST_LO = 2'd2;
  typedef enum logic [2:0] {OP_NONE, OP_DDRAM, OP_ENTRY, OP_HOME, OP_CLEAR} lcd_op_e;
  // masks demand zero upper bits, so function-set, shift and display-control fall to OP_NONE
  function automatic lcd_op_e lcd_op(input logic [7:0] b);
    return (b & CMD_DDRAM_MASK) == CMD_DDRAM ? OP_DDRAM :
           (b & CMD_ENTRY_MASK) == CMD_ENTRY ? OP_ENTRY :
           (b & CMD_HOME_MASK) == CMD_HOME ? OP_HOME :
           b == CMD_CLEAR ? OP_CLEAR : OP_NONE;
  endfunction
endpackage

// File: rtl/lcd_cursor_step.sv
// lcd_cursor_step: next DDRAM address on the 2-line map, wrapping line ends into the other line
module lcd_cursor_step
  import lcd_pkg::*;
(
  input  logic [6:0] cur,
  input  logic       inc,
  output logic [6:0] next
);
  always_comb
    next = inc ? (cur == LINE0_END ? LINE1_BASE : cur == LINE1_END ? LINE0_BASE : cur + 7'd1)
               : (cur == LINE1_BASE ? LINE0_END : cur == LINE0_BASE ? LINE1_END : cur - 7'd1);
endmodule

// File: rtl/lcd_bus_decoder.sv
// lcd_bus_decoder: passive HD44780 4-bit bus follower producing decoded bytes and shadow-buffer writes
module lcd_bus_decoder
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] lcd,
  output logic       four_bit,
  output logic       byte_valid,
  output logic       byte_rs,
  output logic [7:0] byte_data,
  output logic       char_we,
  output logic [4:0] char_addr,
  output logic [7:0] char_data,
  output logic       clear_pulse,
  output logic [6:0] cursor
);
  logic [5:0] s1_q, s2_q;
  logic       e_q;
  logic [1:0] state_q, state_d;
  logic [3:0] hi_q, hi_d;
  logic       hi_rs_q, hi_rs_d;
  logic       inc_q, inc_d;
  logic [6:0] cursor_q, cursor_d, cursor_nx;
  logic       byte_valid_q, byte_valid_d;
  logic       byte_rs_q, byte_rs_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       char_we_q, char_we_d;
  logic [4:0] char_addr_q, char_addr_d;
  logic [7:0] char_data_q, char_data_d;
  logic       clear_pulse_q, clear_pulse_d;
  logic       fall, rs;
  logic [3:0] nib;
  logic [7:0] byte_w;
  lcd_op_e    op;
  assign fall = e_q & ~s2_q[LCD_E];
  assign nib = s2_q[LCD_D_HI:LCD_D_LO];
  assign rs = s2_q[LCD_RS];
  assign byte_w = {hi_q, nib};
  assign op = lcd_op(byte_w);
  lcd_cursor_step u_step (.cur(cursor_q), .inc(inc_q), .next(cursor_nx));
  always_comb begin
    state_d = state_q;
    hi_d = hi_q;
    hi_rs_d = hi_rs_q;
    inc_d = inc_q;
    cursor_d = cursor_q;
    byte_valid_d = 1'b0;
    byte_rs_d = byte_rs_q;
    byte_data_d = byte_data_q;
    char_we_d = 1'b0;
    char_addr_d = char_addr_q;
    char_data_d = char_data_q;
    clear_pulse_d = 1'b0;
    if (fall)
      case (state_q)
        ST_INIT8: state_d = (!rs && nib == NIB_INIT_4BIT) ? ST_HI : ST_INIT8;
        ST_HI: begin
          hi_d = nib;
          hi_rs_d = rs;
          state_d = ST_LO;
        end
        ST_LO: begin
          state_d = ST_HI;
          byte_valid_d = 1'b1;
          byte_rs_d = hi_rs_q;
          byte_data_d = byte_w;
          if (hi_rs_q) begin
            char_we_d = cursor_q[5:4] == 2'b00;
            char_addr_d = {cursor_q[6], cursor_q[3:0]};
            char_data_d = byte_w;
            cursor_d = cursor_nx;
          end else begin
            cursor_d = op == OP_DDRAM ? byte_w[6:0] : (op == OP_HOME || op == OP_CLEAR) ? LINE0_BASE : cursor_q;
            inc_d = op == OP_ENTRY ? byte_w[1] : op == OP_CLEAR ? 1'b1 : inc_q;
            clear_pulse_d = op == OP_CLEAR;
          end
        end
        default: state_d = ST_INIT8;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      e_q <= 1'b0;
      state_q <= ST_INIT8;
      hi_q <= '0;
      hi_rs_q <= 1'b0;
      inc_q <= 1'b1;
      cursor_q <= LINE0_BASE;
      byte_valid_q <= 1'b0;
      byte_rs_q <= 1'b0;
      byte_data_q <= '0;
      char_we_q <= 1'b0;
      char_addr_q <= '0;
      char_data_q <= '0;
      clear_pulse_q <= 1'b0;
    end else begin
      s1_q <= lcd;
      s2_q <= s1_q;
      e_q <= s2_q[LCD_E];
      state_q <= state_d;
      hi_q <= hi_d;
      hi_rs_q <= hi_rs_d;
      inc_q <= inc_d;
      cursor_q <= cursor_d;
      byte_valid_q <= byte_valid_d;
      byte_rs_q <= byte_rs_d;
      byte_data_q <= byte_data_d;
      char_we_q <= char_we_d;
      char_addr_q <= char_addr_d;
      char_data_q <= char_data_d;
      clear_pulse_q <= clear_pulse_d;
    end
  assign four_bit = state_q != ST_INIT8;
  assign byte_valid = byte_valid_q;
  assign byte_rs = byte_rs_q;
  assign byte_data = byte_data_q;
  assign char_we = char_we_q;
  assign char_addr = char_addr_q;
  assign char_data = char_data_q;
  assign clear_pulse = clear_pulse_q;
  assign cursor = cursor_q;
endmodule

// File: tb/tb_lcd_bus_decoder.sv
// tb_lcd_bus_decoder: directed plus randomized LCD bus traffic checked against a behavioural display model
module tb_lcd_bus_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] lcd = '0;
  logic       four_bit, byte_valid, byte_rs, char_we, clear_pulse;
  logic [7:0] byte_data, char_data;
  logic [4:0] char_addr;
  logic [6:0] cursor;
  int checks = 0;
  int failures = 0;
  bit         m_four, m_have_hi, m_hi_rs, m_inc;
  logic [3:0] m_hi;
  int         m_cur;
  bit         e_bv, e_brs, e_we, e_clr;
  logic [7:0] e_bd, e_cd;
  logic [4:0] e_ca;

  lcd_bus_decoder dut (
    .clk(clk), .rst_n(rst_n), .lcd(lcd), .four_bit(four_bit), .byte_valid(byte_valid),
    .byte_rs(byte_rs), .byte_data(byte_data), .char_we(char_we), .char_addr(char_addr),
    .char_data(char_data), .clear_pulse(clear_pulse), .cursor(cursor)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int step(input int c, input bit inc);
    if (inc) return c == 39 ? 64 : c == 103 ? 0 : (c + 1) % 128;
    return c == 64 ? 39 : c == 0 ? 103 : (c + 127) % 128;
  endfunction

  task automatic model_reset();
    m_four = 0; m_have_hi = 0; m_hi_rs = 0; m_inc = 1; m_hi = 0; m_cur = 0;
  endtask

  task automatic model_nib(input bit rs, input logic [3:0] n);
    logic [7:0] b;
    e_bv = 0; e_we = 0; e_clr = 0;
    if (!m_four) begin
      if (!rs && n == 4'h2) m_four = 1;
    end else if (!m_have_hi) begin
      m_hi = n; m_hi_rs = rs; m_have_hi = 1;
    end else begin
      b = {m_hi, n};
      m_have_hi = 0; e_bv = 1; e_brs = m_hi_rs; e_bd = b;
      if (m_hi_rs) begin
        if (m_cur % 64 < 16) begin
          e_we = 1;
          e_ca = 5'((m_cur / 64) * 16 + m_cur % 16);
          e_cd = b;
        end
        m_cur = step(m_cur, m_inc);
      end else if (b >= 128) m_cur = int'(b) - 128;
      else if (b == 1) begin m_cur = 0; m_inc = 1; e_clr = 1; end
      else if (b == 2 || b == 3) m_cur = 0;
      else if (b >= 4 && b < 8) m_inc = b[1];
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_four_bit"}, 32'(four_bit), 0);
    chk({tag, "_byte_valid"}, 32'(byte_valid), 0);
    chk({tag, "_byte_rs"}, 32'(byte_rs), 0);
    chk({tag, "_byte_data"}, 32'(byte_data), 0);
    chk({tag, "_char_we"}, 32'(char_we), 0);
    chk({tag, "_char_addr"}, 32'(char_addr), 0);
    chk({tag, "_char_data"}, 32'(char_data), 0);
    chk({tag, "_clear"}, 32'(clear_pulse), 0);
    chk({tag, "_cursor"}, 32'(cursor), 0);
  endtask

  // E falls at the pins in cycle t; the decoded result must appear in exactly t+3
  task automatic send_nib(input bit rs, input logic [3:0] n);
    bit fb0;
    fb0 = m_four;
    @(posedge clk); #1 lcd = {1'b1, rs, n};
    repeat (3) @(posedge clk);
    #1 lcd = {1'b0, rs, n};
    model_nib(rs, n);
    @(posedge clk); #1 chk("bv_t1", 32'(byte_valid), 0);
    @(posedge clk); #1 chk("bv_t2", 32'(byte_valid), 0);
    chk("four_bit_t2", 32'(four_bit), 32'(fb0));
    @(posedge clk); #1 chk("byte_valid", 32'(byte_valid), 32'(e_bv));
    if (e_bv) begin
      chk("byte_rs", 32'(byte_rs), 32'(e_brs));
      chk("byte_data", 32'(byte_data), 32'(e_bd));
    end
    chk("char_we", 32'(char_we), 32'(e_we));
    if (e_we) begin
      chk("char_addr", 32'(char_addr), 32'(e_ca));
      chk("char_data", 32'(char_data), 32'(e_cd));
    end
    chk("clear_pulse", 32'(clear_pulse), 32'(e_clr));
    chk("cursor", 32'(cursor), 32'(m_cur));
    chk("four_bit", 32'(four_bit), 32'(m_four));
    @(posedge clk); #1 chk("bv_t4", 32'(byte_valid), 0);
    chk("we_t4", 32'(char_we), 0);
    chk("clr_t4", 32'(clear_pulse), 0);
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] b);
    send_nib(rs, b[7:4]);
    send_nib(rs, b[3:0]);
  endtask

  task automatic init_seq();
    send_nib(0, 4'h3);
    send_nib(0, 4'h3);
    send_nib(0, 4'h3);
    send_nib(0, 4'h2);
  endtask

  initial begin
    int r;
    logic [7:0] b;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    rst_n = 1'b1;
    init_seq();
    send_byte(0, 8'h28);
    send_byte(0, 8'hC5);
    send_byte(1, 8'h31);
    send_byte(0, 8'hA7);
    send_byte(1, 8'h41);
    send_byte(0, 8'hE7);
    send_byte(1, 8'h42);
    send_byte(0, 8'h01);
    send_byte(0, 8'h04);
    send_byte(1, 8'h43);
    send_byte(1, 8'h44);
    send_byte(0, 8'h06);
    send_byte(0, 8'hFF);
    send_byte(1, 8'h45);
    send_nib(1, 4'h4);
    send_nib(0, 4'h6);
    @(posedge clk); #2 lcd[5] = 1'b1;
    #3 lcd[5] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 chk("glitch_bv", 32'(byte_valid), 0);
    end
    send_byte(1, 8'h47);
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      b = 8'($urandom);
      if (r <= 3) send_byte(1, b);
      else if (r == 4) send_byte(0, b | 8'h80);
      else if (r == 5) send_byte(0, 8'h04 | (b & 8'h03));
      else if (r == 6) send_byte(0, 8'h02 | (b & 8'h01));
      else if (r == 7) send_byte(0, 8'h01);
      else if (r == 8) send_byte(0, b[0] ? (8'h10 | (b & 8'h0F)) : (8'h20 | (b & 8'h1F)));
      else send_byte(0, b & 8'h7F);
    end
    send_nib(0, 4'hA);
    @(posedge clk); #1 rst_n = 1'b0;
    #2 chk_all_zero("midreset");
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    send_nib(0, 4'h3);
    send_nib(0, 4'h3);
    init_seq();
    send_byte(0, 8'h8F);
    send_byte(1, 8'h5A);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
